// File: rtl/merac_datapath.sv
// Execution datapath of the merac 8-bit CPU: sixteen-entry register file with two
// write ports and two combinational read ports feeding a combinational ALU.
module merac_datapath #(
  parameter int WIDTH_WORD = 8,
  parameter int WIDTH_SEG  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we0,
  input  logic [WIDTH_SEG-1:0]    waddr0,
  input  logic [WIDTH_WORD-1:0]   wdata0,
  input  logic                    we1,
  input  logic [WIDTH_SEG-1:0]    waddr1,
  input  logic [WIDTH_WORD-1:0]   wdata1,
  input  logic [WIDTH_SEG-1:0]    raddr0,
  output logic [WIDTH_WORD-1:0]   rdata0,
  input  logic [WIDTH_SEG-1:0]    raddr1,
  output logic [WIDTH_WORD-1:0]   rdata1,
  output logic [2*WIDTH_WORD-1:0] rpair,
  input  logic                    alu_en,
  input  logic [2:0]              alu_func,
  output logic [WIDTH_WORD-1:0]   alu_result,
  output logic                    alu_carry
);

  localparam int NUM_REGS = 2 ** WIDTH_SEG;

  logic [WIDTH_WORD-1:0] regs_q [NUM_REGS];
  logic [WIDTH_WORD-1:0] regs_d [NUM_REGS];
  logic [WIDTH_WORD:0]   sum_s;
  logic [WIDTH_WORD:0]   diff_s;

  // Next register-file contents; port 1 is applied last so it wins a same-index collision.
  always_comb begin
    regs_d = regs_q;
    if (we0) begin
      regs_d[waddr0] = wdata0;
    end else begin
      regs_d[waddr0] = regs_q[waddr0];
    end
    if (we1) begin
      regs_d[waddr1] = wdata1;
    end else begin
      regs_d[waddr1] = regs_d[waddr1];
    end
  end

  // Register storage with synchronous active-low clear that overrides writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata0 = regs_q[raddr0];
  assign rdata1 = regs_q[raddr1];
  assign rpair  = {rdata1, rdata0};

  assign sum_s  = {1'b0, rdata0} + {1'b0, rdata1};
  // The extra MSB of a zero-extended subtraction is exactly the borrow (A < B).
  assign diff_s = {1'b0, rdata0} - {1'b0, rdata1};

  // ALU function decode; reserved codes and alu_en=0 produce zero with no carry.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    if (alu_en) begin
      case (alu_func)
        3'b000: begin
          alu_result = sum_s[WIDTH_WORD-1:0];
          alu_carry  = sum_s[WIDTH_WORD];
        end
        3'b001: begin
          alu_result = diff_s[WIDTH_WORD-1:0];
          alu_carry  = diff_s[WIDTH_WORD];
        end
        3'b010: alu_result = rdata0 | rdata1;
        3'b011: alu_result = ~rdata0;
        3'b100: alu_result = rdata0;
        default: begin
          alu_result = '0;
          alu_carry  = 1'b0;
        end
      endcase
    end else begin
      alu_result = '0;
      alu_carry  = 1'b0;
    end
  end

endmodule

// File: tb/tb_merac_datapath.sv
// Self-checking bench for merac_datapath: directed table, hand-written corner
// sequences and randomized traffic against an array-based reference model.
module tb_merac_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we0, we1;
  logic [3:0]  waddr0, waddr1, raddr0, raddr1;
  logic [7:0]  wdata0, wdata1;
  logic [7:0]  rdata0, rdata1;
  logic [15:0] rpair;
  logic        alu_en;
  logic [2:0]  alu_func;
  logic [7:0]  alu_result;
  logic        alu_carry;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [16];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic [2:0] func;
    logic [7:0] exp_res;
    logic       exp_c;
  } vec_t;

  vec_t vecs [12];

  merac_datapath #(.WIDTH_WORD(8), .WIDTH_SEG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .rdata0(rdata0),
    .raddr1(raddr1), .rdata1(rdata1),
    .rpair(rpair),
    .alu_en(alu_en), .alu_func(alu_func),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU from the arithmetic definition of each function.
  task automatic ref_alu(input int a, input int b, input logic en, input logic [2:0] f,
                         output logic [7:0] res, output logic c);
    int s;
    res = 8'd0;
    c = 1'b0;
    if (en) begin
      case (f)
        3'd0: begin s = a + b; res = 8'(s % 256); c = (s > 255); end
        3'd1: begin res = 8'((a - b + 256) % 256); c = (a < b); end
        3'd2: res = 8'(a) | 8'(b);
        3'd3: res = 8'(255 - a);
        3'd4: res = 8'(a);
        default: res = 8'd0;
      endcase
    end
  endtask

  // One rising edge; model updates with port 1 applied after port 0, reset wins.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) model[i] = 8'd0;
    end else begin
      if (we0) model[waddr0] = wdata0;
      if (we1) model[waddr1] = wdata1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] er;
    logic ec;
    #1;
    ref_alu(int'(model[raddr0]), int'(model[raddr1]), alu_en, alu_func, er, ec);
    chk({tag, "_rdata0"}, {8'd0, rdata0}, {8'd0, model[raddr0]});
    chk({tag, "_rdata1"}, {8'd0, rdata1}, {8'd0, model[raddr1]});
    chk({tag, "_rpair"}, rpair, {model[raddr1], model[raddr0]});
    chk({tag, "_alu_res"}, {8'd0, alu_result}, {8'd0, er});
    chk({tag, "_alu_c"}, {15'd0, alu_carry}, {15'd0, ec});
  endtask

  initial begin
    vecs[0]  = '{8'd200, 8'd100, 1'b1, 3'd0, 8'd44,  1'b1};
    vecs[1]  = '{8'd5,   8'd8,   1'b1, 3'd1, 8'd253, 1'b1};
    vecs[2]  = '{8'd8,   8'd5,   1'b1, 3'd1, 8'd3,   1'b0};
    vecs[3]  = '{8'h0F,  8'hA0,  1'b1, 3'd2, 8'hAF,  1'b0};
    vecs[4]  = '{8'h0F,  8'h77,  1'b1, 3'd3, 8'hF0,  1'b0};
    vecs[5]  = '{8'h5A,  8'h33,  1'b1, 3'd4, 8'h5A,  1'b0};
    vecs[6]  = '{8'h5A,  8'h33,  1'b0, 3'd0, 8'h00,  1'b0};
    vecs[7]  = '{8'hFF,  8'h01,  1'b1, 3'd0, 8'h00,  1'b1};
    vecs[8]  = '{8'h12,  8'h34,  1'b1, 3'd5, 8'h00,  1'b0};
    vecs[9]  = '{8'h12,  8'h34,  1'b1, 3'd7, 8'h00,  1'b0};
    vecs[10] = '{8'h00,  8'h00,  1'b1, 3'd1, 8'h00,  1'b0};
    vecs[11] = '{8'h80,  8'h80,  1'b1, 3'd0, 8'h00,  1'b1};

    rst_n = 1'b0; we0 = 1'b0; we1 = 1'b0;
    waddr0 = 4'd0; waddr1 = 4'd0; wdata0 = 8'd0; wdata1 = 8'd0;
    raddr0 = 4'd0; raddr1 = 4'd0; alu_en = 1'b1; alu_func = 3'd0;
    for (int i = 0; i < 16; i++) model[i] = 8'd0;
    step(); step();
    rst_n = 1'b1;
    check_all("after_reset");

    // Preload every register nonzero, then reset while a write is requested.
    for (int i = 0; i < 8; i++) begin
      we0 = 1'b1; waddr0 = 4'(2 * i);     wdata0 = 8'(2 * i + 1);
      we1 = 1'b1; waddr1 = 4'(2 * i + 1); wdata1 = 8'(2 * i + 2);
      step();
    end
    raddr0 = 4'd15; raddr1 = 4'd0;
    chk("preload_r15", {8'd0, rdata0}, 16'd16);
    we1 = 1'b0;
    rst_n = 1'b0; we0 = 1'b1; waddr0 = 4'd5; wdata0 = 8'h77;
    step();
    rst_n = 1'b1; we0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      raddr0 = 4'(i); #1;
      chk($sformatf("reset_r%0d", i), {8'd0, rdata0}, 16'd0);
    end

    // Table of ALU vectors, operands loaded into r10/r11.
    for (int i = 0; i < 12; i++) begin
      we0 = 1'b1; waddr0 = 4'd10; wdata0 = vecs[i].a;
      we1 = 1'b1; waddr1 = 4'd11; wdata1 = vecs[i].b;
      step();
      we0 = 1'b0; we1 = 1'b0;
      raddr0 = 4'd10; raddr1 = 4'd11;
      alu_en = vecs[i].en; alu_func = vecs[i].func;
      #1;
      chk($sformatf("vec%0d_res", i), {8'd0, alu_result}, {8'd0, vecs[i].exp_res});
      chk($sformatf("vec%0d_carry", i), {15'd0, alu_carry}, {15'd0, vecs[i].exp_c});
    end

    // r1=8, r3=5, ADD, write back into r2.
    we0 = 1'b1; waddr0 = 4'd1; wdata0 = 8'd8;
    we1 = 1'b1; waddr1 = 4'd3; wdata1 = 8'd5;
    step();
    we1 = 1'b0;
    raddr0 = 4'd3; raddr1 = 4'd1; alu_en = 1'b1; alu_func = 3'd0;
    #1;
    chk("add_13", {7'd0, alu_carry, alu_result}, 16'd13);
    waddr0 = 4'd2; wdata0 = alu_result;
    step();
    we0 = 1'b0; raddr0 = 4'd2;
    #1;
    chk("writeback_r2", {8'd0, rdata0}, 16'd13);

    // PC pair.
    we0 = 1'b1; waddr0 = 4'd14; wdata0 = 8'h08;
    we1 = 1'b1; waddr1 = 4'd15; wdata1 = 8'h01;
    step();
    we0 = 1'b0; we1 = 1'b0; raddr0 = 4'd14; raddr1 = 4'd15;
    #1;
    chk("pc_pair", rpair, 16'h0108);

    // Same-index collision: port 1 wins.
    we0 = 1'b1; waddr0 = 4'd7; wdata0 = 8'h11;
    we1 = 1'b1; waddr1 = 4'd7; wdata1 = 8'h22;
    step();
    we0 = 1'b0; we1 = 1'b0; raddr0 = 4'd7;
    #1;
    chk("collision_r7", {8'd0, rdata0}, 16'h0022);

    // Read during write returns the old value until the edge.
    we0 = 1'b1; waddr0 = 4'd4; wdata0 = 8'h33;
    step();
    wdata0 = 8'h44; raddr0 = 4'd4;
    #1;
    chk("rdw_before", {8'd0, rdata0}, 16'h0033);
    step();
    we0 = 1'b0;
    chk("rdw_after", {8'd0, rdata0}, 16'h0044);
    check_all("directed_end");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      we0    = 1'($urandom);      we1    = 1'($urandom);
      waddr0 = 4'($urandom);      waddr1 = 4'($urandom);
      wdata0 = 8'($urandom);      wdata1 = 8'($urandom);
      raddr0 = 4'($urandom);      raddr1 = 4'($urandom);
      alu_en = ($urandom_range(0, 7) != 0);
      alu_func = 3'($urandom);
      check_all("rand_pre");
      step();
      check_all("rand_post");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
